// File: rtl/shape_processor_pkg.sv
// shape_processor_pkg: CTRL SFR layout, field encodings and legality helpers
// shared by the command issuer and the shape_processor properties.
package shape_processor_pkg;
    localparam int CMD_W = 7;

    typedef enum logic [1:0] {
        SHAPE_NONE = 2'b00,
        RECTANGLE  = 2'b01,
        TRIANGLE   = 2'b10,
        SHAPE_RSVD = 2'b11
    } shape_e;

    typedef enum logic [4:0] {
        OP_NONE        = 5'b00000,
        AREA           = 5'b00001,
        IS_SQUARE      = 5'b01000,
        IS_EQUILATERAL = 5'b10000,
        IS_ISOSCELES   = 5'b10001
    } operation_e;

    typedef struct packed {
        logic [13:0] reserved1;
        logic [1:0]  SHAPE;
        logic [10:0] reserved0;
        logic [4:0]  OPERATION;
    } ctrl_sfr_reg;

    function automatic logic is_legal_shape(input logic [1:0] s);
        return s == RECTANGLE || s == TRIANGLE;
    endfunction

    function automatic logic is_legal_operation(input logic [4:0] op);
        return op inside {OP_NONE, AREA, IS_SQUARE, IS_EQUILATERAL, IS_ISOSCELES};
    endfunction

    function automatic logic is_legal_combination(input logic [1:0] s, input logic [4:0] op);
        return is_legal_shape(s) && is_legal_operation(op)
            && !(op == IS_SQUARE && s != RECTANGLE)
            && !((op == IS_EQUILATERAL || op == IS_ISOSCELES) && s != TRIANGLE);
    endfunction

    function automatic ctrl_sfr_reg ctrl_word(input logic [1:0] s, input logic [4:0] op);
        return '{reserved1: '0, SHAPE: s, reserved0: '0, OPERATION: op};
    endfunction
endpackage

// File: rtl/shape_cmd_fifo.sv
// shape_cmd_fifo: synchronous FIFO, no bypass from push to pop.
//   push/push_data in, pop in (ignored when empty), full/empty out,
//   pop_data shows the head entry combinationally.
module shape_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] pop_data
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty    = wr_ptr == rd_ptr;
    assign full     = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk)
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/shape_cmd_issuer.sv
// shape_cmd_issuer: buffers (shape, operation) commands, rejects illegal ones
// locally, writes legal ones to the CTRL SFR and confirms them by read-back.
//   cmd_valid/cmd_ready/cmd_shape/cmd_operation : command stream in
//   write/write_data/read/read_data/error       : CTRL SFR register port
//   rsp_valid/rsp_ready/rsp_data/rsp_error      : one response per command
//   reject_count                                : saturating error-response count
module shape_cmd_issuer
    import shape_processor_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_shape,
    input  logic [4:0]       cmd_operation,
    output logic             write,
    output logic [31:0]      write_data,
    output logic             read,
    input  logic [31:0]      read_data,
    input  logic             error,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_error,
    output logic [CNT_W-1:0] reject_count
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;

    state_e           state, state_nx;
    ctrl_sfr_reg      cmd_q;
    logic             err_q;
    logic             full, empty, pop, legal;
    logic [CMD_W-1:0] head;

    assign cmd_ready = !full;
    assign pop       = state == IDLE && !empty;
    assign legal     = is_legal_combination(head[6:5], head[4:0]);

    shape_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid && cmd_ready),
        .push_data ({cmd_shape, cmd_operation}),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .pop_data  (head)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = empty ? IDLE : legal ? WRITE : RESP;
            WRITE:   state_nx = READ;
            READ:    state_nx = RESP;
            default: state_nx = rsp_ready ? IDLE : RESP;
        endcase
    end

    always_comb begin
        write      = state == WRITE;
        write_data = write ? cmd_q : '0;
        read       = state == READ;
        rsp_valid  = state == RESP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q        <= '0;
            err_q        <= 1'b0;
            rsp_data     <= '0;
            rsp_error    <= 1'b0;
            reject_count <= '0;
        end else begin
            if (pop) cmd_q <= ctrl_word(head[6:5], head[4:0]);
            // Locally rejected commands never touch the SFR port.
            if (pop && !legal) begin
                rsp_data  <= '0;
                rsp_error <= 1'b1;
            end
            if (state == WRITE) err_q <= error;
            if (state == READ) begin
                rsp_data  <= read_data;
                rsp_error <= err_q || read_data != cmd_q;
            end
            if (rsp_valid && rsp_ready && rsp_error && !(&reject_count))
                reject_count <= reject_count + CNT_W'(1);
        end
    end
endmodule
